// File: rtl/subbytes_seq_ctrl.sv
// Time-multiplexed AES SubBytes: one 128-bit state pushed through LANES shared S-boxes, LANES bytes per beat.
// Optional macro SUBBYTES_SBOX_REG_EN adds a register stage after the S-boxes (one extra SUB cycle).
module subbytes_seq_ctrl #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned BEATS  = (LANES == 0) ? 1 : 16 / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (LANES == 0 || LANES > 16 || (16 % LANES) != 0) begin : g_bad_lanes
        $error("subbytes_seq_ctrl: LANES=%0d must divide 16", LANES);
    end

    // Forward AES S-box, entry 0 first
    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[x];
    endfunction

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t                 state_q;
    logic [BEAT_W-1:0]      beat_q;
    logic [0:15][7:0]       buffer_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic [0:LANES-1][7:0]  lane_res_c;
    logic [0:LANES-1][7:0]  wr_res_c;
    logic [BEAT_W-1:0]      wr_beat_c;
    logic                   wr_en_c;
    logic                   last_wr_c;
    logic [0:15][7:0]       buffer_next_c;

    // Lane l of the current beat looks up byte beat*LANES+l
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0] idx;
        assign idx           = 4'(32'(beat_q) * LANES + l);
        assign lane_res_c[l] = sbox(buffer_q[idx]);
    end

`ifdef SUBBYTES_SBOX_REG_EN
    logic [0:LANES-1][7:0]  wb_res_q;
    logic [BEAT_W-1:0]      wb_beat_q;
    logic                   wb_valid_q;
    logic                   issue_done_q;

    assign wr_en_c   = (state_q == SUB) && wb_valid_q;
    assign wr_beat_c = wb_beat_q;
    assign wr_res_c  = wb_res_q;
`else
    assign wr_en_c   = (state_q == SUB);
    assign wr_beat_c = beat_q;
    assign wr_res_c  = lane_res_c;
`endif

    assign last_wr_c = wr_en_c && (wr_beat_c == LAST_BEAT);

    // Byte i belongs to beat i/LANES, lane i%LANES
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int unsigned BI = i / LANES;
        localparam int unsigned LI = i % LANES;
        assign buffer_next_c[i] = (wr_beat_c == BEAT_W'(BI)) ? wr_res_c[LI] : buffer_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            buffer_q     <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SUBBYTES_SBOX_REG_EN
            wb_res_q     <= '0;
            wb_beat_q    <= '0;
            wb_valid_q   <= 1'b0;
            issue_done_q <= 1'b0;
`endif
        end else begin
            if (wr_en_c) begin
                buffer_q <= buffer_next_c;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        buffer_q   <= in_data;
                        beat_q     <= '0;
                        state_q    <= SUB;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef SUBBYTES_SBOX_REG_EN
                        wb_valid_q   <= 1'b0;
                        issue_done_q <= 1'b0;
`endif
                    end
                end
                SUB: begin
`ifdef SUBBYTES_SBOX_REG_EN
                    // Issue side runs one beat ahead of the write-back register
                    if (!issue_done_q) begin
                        wb_res_q   <= lane_res_c;
                        wb_beat_q  <= beat_q;
                        wb_valid_q <= 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            issue_done_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end else begin
                        wb_valid_q <= 1'b0;
                    end
`else
                    if (beat_q != LAST_BEAT) begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
`endif
                    if (last_wr_c) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = buffer_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_subbytes_seq_ctrl.sv
// Directed bench for subbytes_seq_ctrl: three instances (LANES 4, 1, 16) driven from one vector table.
module tb_subbytes_seq_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] in_data_a   [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] out_data_a  [3];
    logic         busy_a      [3];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 4 : (g == 1) ? 1 : 16;
        subbytes_seq_ctrl #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_data   (in_data_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_data  (out_data_a[g]),
            .busy      (busy_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lanes_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 16;
    endfunction

    // Posedges from the input handshake edge to the first edge showing out_valid
    function automatic int exp_lat(input int k);
`ifdef SUBBYTES_SBOX_REG_EN
        return 16 / lanes_of(k) + 1;
`else
        return 16 / lanes_of(k);
`endif
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_valid(input int k, output int n);
        n = 0;
        while (out_valid_a[k] !== 1'b1 && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    // Full transaction on instance k; hold = cycles out_ready stays low in DONE
    task automatic xfer(input int k, input logic [127:0] din, input logic [127:0] exp, input int hold);
        int n;
        chk("rdy_idle", 128'(in_ready_a[k]), 128'(1));
        in_valid_a[k]  = 1'b1;
        in_data_a[k]   = din;
        out_ready_a[k] = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid_a[k] = 1'b0;
        in_data_a[k]  = ~din;
        chk("rdy_sub", 128'(in_ready_a[k]), 128'(0));
        chk("busy_sub", 128'(busy_a[k]), 128'(1));
        wait_valid(k, n);
        chk("latency", 128'(n), 128'(exp_lat(k)));
        chk("data", out_data_a[k], exp);
        chk("rdy_done", 128'(in_ready_a[k]), 128'(0));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 128'(out_valid_a[k]), 128'(1));
            chk("hold_data", out_data_a[k], exp);
            chk("hold_rdy", 128'(in_ready_a[k]), 128'(0));
        end
        out_ready_a[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("valid_drop", 128'(out_valid_a[k]), 128'(0));
        chk("rdy_back", 128'(in_ready_a[k]), 128'(1));
        chk("busy_drop", 128'(busy_a[k]), 128'(0));
        out_ready_a[k] = 1'b0;
    endtask

    typedef struct {
        int           k;
        logic [127:0] din;
        logic [127:0] exp;
        int           hold;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid_a[k]  = 1'b0;
            in_data_a[k]   = '0;
            out_ready_a[k] = 1'b0;
        end

        vecs[0] = '{0, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816, 0};
        vecs[1] = '{0, 128'h0,                                128'h63636363636363636363636363636363, 10};
        vecs[2] = '{0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 0};
        vecs[3] = '{0, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76, 2};
        vecs[4] = '{1, 128'ha49c7ff2689f352b6b5bea43026a5049, 128'h49ded28945db96f17f39871a7702533b, 0};
        vecs[5] = '{1, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76, 0};
        vecs[6] = '{2, 128'hffffffffffffffffffffffffffffffff, 128'h16161616161616161616161616161616, 0};
        vecs[7] = '{2, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_rdy", 128'(in_ready_a[k]), 128'(1));
            chk("rst_valid", 128'(out_valid_a[k]), 128'(0));
            chk("rst_busy", 128'(busy_a[k]), 128'(0));
            chk("rst_data", out_data_a[k], 128'h0);
        end

        foreach (vecs[i]) begin
            xfer(vecs[i].k, vecs[i].din, vecs[i].exp, vecs[i].hold);
        end

        // Back-to-back: second state accepted one cycle after the first output handshake
        in_valid_a[0]  = 1'b1;
        in_data_a[0]   = 128'h00112233445566778899aabbccddeeff;
        out_ready_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data_a[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        wait_valid(0, n);
        chk("b2b_lat_a", 128'(n), 128'(exp_lat(0)));
        chk("b2b_data_a", out_data_a[0], 128'h638293c31bfc33f5c4eeacea4bc12816);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_gap_rdy", 128'(in_ready_a[0]), 128'(1));
        chk("b2b_gap_busy", 128'(busy_a[0]), 128'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        chk("b2b_accept_rdy", 128'(in_ready_a[0]), 128'(0));
        chk("b2b_accept_busy", 128'(busy_a[0]), 128'(1));
        wait_valid(0, n);
        chk("b2b_lat_b", 128'(n), 128'(exp_lat(0)));
        chk("b2b_data_b", out_data_a[0], 128'hd42711aee0bf98f1b8b45de51e415230);
        @(posedge clk);
        @(negedge clk);
        out_ready_a[0] = 1'b0;
        chk("b2b_end_valid", 128'(out_valid_a[0]), 128'(0));

        // Reset while beat 2 is being substituted
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 128'hffffffffffffffffffffffffffffffff;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 128'(out_valid_a[0]), 128'(0));
        chk("mid_rst_data", out_data_a[0], 128'h0);
        chk("mid_rst_rdy", 128'(in_ready_a[0]), 128'(1));
        chk("mid_rst_busy", 128'(busy_a[0]), 128'(0));
        xfer(0, 128'ha49c7ff2689f352b6b5bea43026a5049, 128'h49ded28945db96f17f39871a7702533b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
